seq_detector_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 5-bit Mealy detector.
- Pattern (up to PAT_W bits) and its length are programmed at run time.
- Selectable overlapping / non-overlapping detection.
- Selectable Mealy (same-cycle) or Moore (registered) match output.
- Saturating match counter.
- Sits on a serial bit stream in the datapath and flags pattern occurrences to control logic.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/sat_counter.sv | 33 +++
 rtl/seq_detector_param.sv | 131 +++++++++++++
 tb/tb_seq_detector_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   state_e : FSM encoding (ST_IDLE = unconfigured / len 0, ST_HUNT = detecting)
//   len_w   : width needed to hold a length in 0..pat_w
package seq_det_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HUNT = 1'b1
   } state_e;

   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock / synchronous active-low reset
//   clr_i      : clear; together with inc_i the result is 1 (the clearing event counts)
//   inc_i      : increment, holds at all-ones
//   cnt_o      : current count
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = inc_i ? CNT_W'(1) : '0;
      else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector.
//   clk, rst_n   : clock / synchronous active-low reset
//   j, j_valid   : serial data bit and its qualifier
//   cfg_load     : latch cfg_pattern/cfg_len/cfg_overlap/cfg_moore, restart hunting
//   cfg_pattern  : pattern, bit [len-1] arrives first, bit [0] last
//   cfg_len      : pattern length, clamped to PAT_W; 0 disarms
//   cfg_overlap  : 1 = a match may share bits with the next one
//   cfg_moore    : 1 = w registered (cycle after final bit), 0 = w same cycle
//   cnt_clr      : clear match counter
//   w            : match flag
//   match_cnt    : saturating match count
//   armed        : detector configured and hunting
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             j,
   input  logic             j_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             cfg_moore,
   input  logic             cnt_clr,
   output logic             w,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovl_q, ovl_d;
   logic             moore_q, moore_d;
   logic             w_q, w_d;

   logic [LEN_W-1:0] eff_len;
   logic             accept;
   logic [PAT_W-1:0] hist_nxt;
   logic [LEN_W-1:0] fill_nxt;
   logic [PAT_W-1:0] len_mask;
   logic             hit;

   assign eff_len  = (cfg_len > PAT_W_L) ? PAT_W_L : cfg_len;
   assign accept   = j_valid & ~cfg_load & (state_q == ST_HUNT);
   assign hist_nxt = {hist_q[PAT_W-2:0], j};
   assign fill_nxt = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_W'(1);

   // Low len_q bits set; len_q == PAT_W shifts everything out -> all ones.
   assign len_mask = ~({PAT_W{1'b1}} << len_q);

   // fill_nxt >= len_q keeps a short history (zeros after load/clear) from
   // matching a pattern that has zeros in its upper bits.
   assign hit = accept
              & (((hist_nxt ^ pat_q) & len_mask) == '0)
              & (fill_nxt >= len_q);

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      moore_d = moore_q;
      w_d     = hit;

      if (cfg_load) begin
         pat_d   = cfg_pattern;
         len_d   = eff_len;
         ovl_d   = cfg_overlap;
         moore_d = cfg_moore;
         hist_d  = '0;
         fill_d  = '0;
         w_d     = 1'b0;
         state_d = (eff_len == '0) ? ST_IDLE : ST_HUNT;
      end else if (accept) begin
         if (hit && !ovl_q) begin
            // Non-overlapping: next match must be built from fresh bits only.
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_nxt;
            fill_d = fill_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         moore_q <= 1'b0;
         w_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         moore_q <= moore_d;
         w_q     <= w_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (hit),
      .cnt_o (match_cnt)
   );

   assign w     = moore_q ? w_q : hit;
   assign armed = (state_q == ST_HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all
// checked against a bit-queue reference model of the detection rules.
module tb_seq_detector_param;

   localparam int PAT_W = 8;
   localparam int CNT_W = 2;
   localparam int LEN_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             j;
   logic             j_valid;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             cfg_moore;
   logic             cnt_clr;
   logic             w;
   logic [CNT_W-1:0] match_cnt;
   logic             armed;

   seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .j           (j),
      .j_valid     (j_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_moore   (cfg_moore),
      .cnt_clr     (cnt_clr),
      .w           (w),
      .match_cnt   (match_cnt),
      .armed       (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
      end
   endtask

   // Reference model: the bits accepted since the last load / non-overlap match.
   bit             q[$];
   bit             m_armed;
   int             m_len;
   bit [PAT_W-1:0] m_pat;
   bit             m_ovl;
   bit             m_moore;
   bit             m_wreg;
   int             m_cnt;

   function automatic bit model_hit(input bit jj, input bit acc);
      bit t[$];
      if (!acc) return 1'b0;
      t = q;
      t.push_back(jj);
      if (t.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++)
         if (t[t.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive at posedge+1, check mid-cycle, update model at posedge.
   task automatic step(input logic jj, input logic jv, input logic ld,
                       input logic clr, input logic rn, output logic wo);
      bit hit;
      int el;
      j = jj; j_valid = jv; cfg_load = ld; cnt_clr = clr; rst_n = rn;
      #4;
      hit = model_hit(jj, jv & ~ld & m_armed);
      if (rn) chk("w", w, m_moore ? m_wreg : hit);
      chk("armed", armed, m_armed);
      chk("cnt", match_cnt, m_cnt);
      wo = w;
      @(posedge clk);
      if (!rn) begin
         m_armed = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_moore = 0;
         m_wreg = 0; m_cnt = 0; q.delete();
      end else begin
         if (clr)                    m_cnt = hit ? 1 : 0;
         else if (hit && m_cnt < CMAX) m_cnt++;
         m_wreg = hit;
         if (ld) begin
            el      = (cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
            m_len   = el;
            m_pat   = cfg_pattern;
            m_ovl   = cfg_overlap;
            m_moore = cfg_moore;
            m_armed = (el != 0);
            m_wreg  = 0;
            q.delete();
         end else if (jv && m_armed) begin
            if (hit && !m_ovl) q.delete();
            else begin
               q.push_back(jj);
               if (q.size() > PAT_W) void'(q.pop_front());
            end
         end
      end
      #1;
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input logic ov, input logic mo, input logic clr);
      logic wo;
      cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_moore = mo;
      // j_valid high with j=1: that bit must be ignored
      step(1'b1, 1'b1, 1'b1, clr, 1'b1, wo);
   endtask

   // Streams bits[n-1] first; returns observed w per bit, first bit in MSB.
   task automatic run_bits(input logic [15:0] bits, input int n, output logic [15:0] wv);
      logic wo;
      wv = '0;
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i], 1'b1, 1'b0, 1'b0, 1'b1, wo);
         wv = {wv[14:0], wo};
      end
   endtask

   initial begin
      logic [15:0] wv, wv2;
      logic        wo;
      j = 0; j_valid = 0; cfg_load = 0; cnt_clr = 0; rst_n = 0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_moore = 0;
      m_armed = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_moore = 0; m_wreg = 0; m_cnt = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_armed", armed, 0);
      chk("rst_cnt", match_cnt, 0);
      chk("rst_w", w, 0);

      // Overlap, Mealy
      load(8'b0001_0010, 4'd5, 1'b1, 1'b0, 1'b1);
      run_bits(16'b1001_0010, 8, wv);
      chk("ovl_mealy_w", wv[7:0], 8'b0000_1001);
      chk("ovl_mealy_cnt", match_cnt, 2);

      // Non-overlap
      load(8'b0001_0010, 4'd5, 1'b0, 1'b0, 1'b1);
      run_bits(16'b1001_0010, 8, wv);
      chk("novl_w", wv[7:0], 8'b0000_1000);
      chk("novl_cnt", match_cnt, 1);

      // Moore timing: one trailing idle cycle to see the second registered hit
      load(8'b0001_0010, 4'd5, 1'b1, 1'b1, 1'b1);
      run_bits(16'b1001_0010, 8, wv);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wo);
      chk("moore_w", {wv[7:0], wo}, 9'b0_0000_1001);
      chk("moore_cnt", match_cnt, 2);

      // Gaps between bits 3 and 4
      load(8'b0001_0010, 4'd5, 1'b1, 1'b0, 1'b1);
      run_bits(16'b100, 3, wv);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wo);
      run_bits(16'b10010, 5, wv2);
      chk("gap_w", {wv[2:0], wv2[4:0]}, 8'b0000_1001);
      chk("gap_cnt", match_cnt, 2);

      // Reconfigure mid-stream: old history ends in 1,0 and must not complete 101
      load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b1);
      run_bits(16'b10101, 5, wv);
      chk("reload_w", wv[4:0], 5'b00101);

      // Counter saturation with len=1
      load(8'h01, 4'd1, 1'b1, 1'b0, 1'b1);
      run_bits(16'b11_1111, 6, wv);
      chk("sat_w", wv[5:0], 6'b11_1111);
      chk("sat_cnt", match_cnt, 3);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, wo);
      chk("clr_hit_cnt", match_cnt, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, wo);
      chk("clr_cnt", match_cnt, 0);

      // Reset mid-match (the completing bit arrives with rst_n low)
      load(8'b0001_0010, 4'd5, 1'b1, 1'b1, 1'b1);
      run_bits(16'b1001, 4, wv);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, wo);
      chk("mid_rst_armed", armed, 0);
      chk("mid_rst_cnt", match_cnt, 0);
      chk("mid_rst_w", w, 0);
      run_bits(16'b1001_0010, 8, wv);
      chk("idle_cnt", match_cnt, 0);

      // len=0 keeps IDLE
      load(8'b0001_0010, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("len0_armed", armed, 0);
      run_bits(16'b1001_0010, 8, wv);
      chk("len0_w", wv[7:0], 8'h00);

      // len=12 clamps to 8
      load(8'hB3, 4'd12, 1'b1, 1'b0, 1'b1);
      chk("len12_armed", armed, 1);
      run_bits(16'b1011_0011, 8, wv);
      chk("len12_w", wv[7:0], 8'b0000_0001);
      chk("len12_cnt", match_cnt, 1);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         logic ld, jv, clr, rn;
         ld  = ($urandom % 40) == 0;
         jv  = ($urandom % 5) != 0;
         clr = ($urandom % 25) == 0;
         rn  = ($urandom % 300) != 0;
         if (ld) begin
            cfg_pattern = PAT_W'($urandom);
            cfg_len     = (($urandom % 10) < 7) ? LEN_W'($urandom_range(1, 4))
                                                : LEN_W'($urandom_range(0, 12));
            cfg_overlap = 1'($urandom);
            cfg_moore   = 1'($urandom);
         end
         step(1'($urandom), jv, ld, clr, rn, wo);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
